// File: rtl/wb_reg_bank_pkg.sv
// wb_reg_bank shared constants and helpers.
// Imported by the interface, the register cell and the top.
package wb_reg_bank_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  function automatic logic [WB_ADDR_W-1:0]
    status_offset(input int num_regs);
    return WB_ADDR_W'(4 * num_regs);
  endfunction

  function automatic logic [WB_DATA_W-1:0]
    byte_mask(input logic [WB_SEL_W-1:0] sel);
    logic [WB_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < WB_SEL_W; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction
endpackage

// File: rtl/wb_reg_bank_if.sv
// Wishbone slave bus bundle for wb_reg_bank.
// The master drives the request, the slave returns ack and data.
interface wb_reg_bank_if;
  import wb_reg_bank_pkg::*;

  logic                 wbs_stb_i;
  logic                 wbs_cyc_i;
  logic                 wbs_we_i;
  logic [WB_SEL_W-1:0]  wbs_sel_i;
  logic [WB_DATA_W-1:0] wbs_dat_i;
  logic [WB_ADDR_W-1:0] wbs_adr_i;
  logic                 wbs_ack_o;
  logic [WB_DATA_W-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_reg_bank_cell.sv
// One byte-maskable control register with a reset value.
// Bits with mask=1 take d when we is high.
module wb_reg_bank_cell #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [W-1:0] mask,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d = (q_q & ~mask) | (d & mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/wb_reg_bank.sv
// Wishbone register bank: NUM_REGS R/W regs plus one status reg.
// Define WB_REG_BANK_STATUS_W1C_EN for a sticky write-1-to-clear status.
module wb_reg_bank
  import wb_reg_bank_pkg::*;
#(
  parameter logic [31:0]          BASE_ADDR   = 32'h3000_0000,
  parameter int                   NUM_REGS    = 4,
  parameter int                   REG_WIDTH   = 32,
  parameter logic [REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  wb_reg_bank_if.slave                  wb,
  input  logic [REG_WIDTH-1:0]          status_i,
  output logic [NUM_REGS*REG_WIDTH-1:0] reg_q_o,
  output logic [NUM_REGS-1:0]           reg_wr_o
);
  localparam int IW = 5;
  localparam logic [WB_ADDR_W-1:0] WIN =
    WB_ADDR_W'(4 * (NUM_REGS + 1));

  logic [WB_ADDR_W-1:0] offset;
  logic [IW-1:0]        idx;
  logic                 hit;
  logic                 accept;
  logic                 wr_en;
  logic                 is_status;
  logic [WB_DATA_W-1:0] mask_full;
  logic [REG_WIDTH-1:0] wmask;
  logic [REG_WIDTH-1:0] wdat;
  logic [REG_WIDTH-1:0] stat_val;
  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [WB_DATA_W-1:0] rd;

  logic                 ack_d, ack_q;
  logic [WB_DATA_W-1:0] dat_d, dat_q;
  logic [NUM_REGS-1:0]  wr_d, wr_q;

  assign offset    = wb.wbs_adr_i - BASE_ADDR;
  assign hit       = (wb.wbs_adr_i >= BASE_ADDR) && (offset < WIN);
  assign idx       = offset[2 +: IW];
  assign is_status =
    ({offset[WB_ADDR_W-1:2], 2'b00} == status_offset(NUM_REGS));
  assign accept    = wb.wbs_stb_i && wb.wbs_cyc_i && hit && !ack_q;
  assign wr_en     = accept && wb.wbs_we_i;
  assign mask_full = byte_mask(wb.wbs_sel_i);
  assign wmask     = mask_full[REG_WIDTH-1:0];
  assign wdat      = wb.wbs_dat_i[REG_WIDTH-1:0];

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    wb_reg_bank_cell #(
      .W       (REG_WIDTH),
      .RST_VAL (RESET_VALUE)
    ) u_cell (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .we    (wr_en && (idx == IW'(k))),
      .mask  (wmask),
      .d     (wdat),
      .q     (regs[k])
    );
    assign reg_q_o[k*REG_WIDTH +: REG_WIDTH] = regs[k];
  end

`ifdef WB_REG_BANK_STATUS_W1C_EN
  logic [REG_WIDTH-1:0] sticky_d, sticky_q;
  logic [REG_WIDTH-1:0] clr;

  // set is ORed in after the clear so a same-cycle set wins
  always_comb begin
    clr = '0;
    if (wr_en && is_status) begin
      clr = wdat & wmask;
    end
    sticky_d = (sticky_q & ~clr) | status_i;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign stat_val = sticky_q;
`else
  assign stat_val = status_i;
`endif

  always_comb begin
    rd = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (idx == IW'(k)) begin
        rd[REG_WIDTH-1:0] = regs[k];
      end
    end
    if (is_status) begin
      rd[REG_WIDTH-1:0] = stat_val;
    end
  end

  always_comb begin
    ack_d = accept;
    dat_d = '0;
    wr_d  = '0;
    if (accept && !wb.wbs_we_i) begin
      dat_d = rd;
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      wr_d[k] = wr_en && (idx == IW'(k));
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      wr_q  <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      wr_q  <= wr_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign reg_wr_o     = wr_q;
endmodule

// File: doc/wb_reg_bank.md
Name: wb_reg_bank

Overview:
Parametrised Wishbone slave register bank that supersedes the single-bit memory-mapped register on the Caravel user bus. It provides NUM_REGS read/write control registers of REG_WIDTH bits, plus one read-only status register. It adds byte-lane writes, a correct single-pulse ack handshake, address-window decode, and per-register write strobes. It sits between the Caravel Wishbone bus (base at or above 0x3000_0000) and user-project control logic.

Parameters:
BASE_ADDR, 32'h3000_0000, word-aligned base address of register 0
NUM_REGS, 4, number of R/W control registers (1..16)
REG_WIDTH, 32, bits per register (1..32)
RESET_VALUE, 0, reset value of every control register (REG_WIDTH bits)

Ports:
wb_clk_i  in  1  Wishbone clock; the only clock
wb_rst_ni  in  1  asynchronous active-low reset
wbs_stb_i  in  1  strobe
wbs_cyc_i  in  1  bus cycle
wbs_we_i  in  1  1 = write, 0 = read
wbs_sel_i  in  4  byte-lane selects
wbs_dat_i  in  32  write data
wbs_adr_i  in  32  byte address
wbs_ack_o  out  1  acknowledge, registered
wbs_dat_o  out  32  read data, registered
status_i  in  REG_WIDTH  status bits exposed at the status offset
reg_q_o  out  NUM_REGS*REG_WIDTH  control registers concatenated; reg k at [k*REG_WIDTH +: REG_WIDTH]
reg_wr_o  out  NUM_REGS  one-cycle pulse per register written

Behaviour:
- Reset (wb_rst_ni low, asynchronous): all registers = RESET_VALUE, wbs_ack_o=0, wbs_dat_o=0, reg_wr_o=0, status sticky bits=0. Reset asserted mid-transaction drops the ack and cancels the transaction; no ack is issued after release for that transaction.
- Window: offset = wbs_adr_i - BASE_ADDR. Hit when BASE_ADDR <= wbs_adr_i < BASE_ADDR + 4*(NUM_REGS+1). adr[1:0] ignored. Index = offset[..:2]. Index 0..NUM_REGS-1 = control regs; index NUM_REGS = status.
- Outside window: no ack, no state change, wbs_dat_o stays 0 (another slave owns the address).
- Accept condition: stb & cyc & hit & !wbs_ack_o. Ack is asserted in the cycle after acceptance for exactly 1 cycle. A held strobe gives one ack per 2 cycles (accept, ack, accept, ...), never a double ack.
- Write: for each byte lane b with sel[b]=1, bits [8b+7:8b] ∩ [REG_WIDTH-1:0] are updated at the accept edge. Bits above REG_WIDTH are ignored. reg_wr_o[idx] pulses in the same cycle as the ack. sel=0000 still acks but changes nothing, and reg_wr_o still pulses.
- Write to status index: acked, no effect (see optional feature).
- Read: wbs_dat_o = zero-extended register value sampled at the accept edge, valid in the ack cycle. wbs_dat_o returns to 0 the cycle after the ack. wbs_sel_i is ignored on reads.
- Status read (feature off): wbs_dat_o = status_i sampled at the accept edge.
- Latency: fixed 1 cycle from accept to ack for reads and writes.

Optional Feature:
WB_REG_BANK_STATUS_W1C_EN
- Defined: status register is sticky. Bit i is set on any cycle where status_i[i]=1. A write to the status index clears bits where dat_i=1, subject to byte selects (write-1-to-clear). If set and clear hit the same bit in the same cycle, set wins. Reads return the sticky value.
- Undefined: status register is a direct sample of status_i, writes are ignored, and no sticky flops exist.

Decomposition:
- Package wb_reg_bank_pkg: WB_ADDR_W=32, WB_DATA_W=32, WB_SEL_W=4, constant STATUS_OFFSET function (4*NUM_REGS), and a byte-mask expansion function (sel -> 32-bit mask).
- Sub-module wb_reg_bank_cell: one REG_WIDTH register with a write enable, byte mask and reset value. It is instantiated NUM_REGS times via generate. Decode, ack and read-mux logic stay in the top.

Test Plan:
- Reset release: reg_q_o = all RESET_VALUE; read BASE+4 -> ack after 1 cycle, dat=0x0000_0000.
- Write 0xDEAD_BEEF, sel=4'b0101, to BASE+8 (reg 2, prior 0) -> reg 2 = 0x00AD_00EF; reg_wr_o=4'b0100 for 1 cycle with ack; read back 0x00AD_00EF.
- REG_WIDTH=8: write 0x1234_5678 to reg 0 -> reg_q_o[7:0]=0x78; read returns 0x0000_0078.
- Strobe held 6 cycles on BASE+0 -> exactly 3 acks, none back-to-back; access to BASE+4*(NUM_REGS+1) -> no ack, dat_o=0.
- Status: status_i=0x5; read BASE+4*NUM_REGS -> 0x5. With W1C_EN: pulse bit 1 for 1 cycle, read -> 0x7; write 0x2 -> 0x5; write 0x1 while status_i[0]=1 -> bit 0 stays 1.
- Assert wb_rst_ni low in the cycle between accept and ack of a write -> no ack, reg = RESET_VALUE after release.
